// File: rtl/ccd_capture_pkg.sv
// ----------------------------------------------------------------------------
// ccd_capture_pkg : shared types, defaults and helpers for the CCD line capture
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ccd_capture_pkg;

    localparam int DEF_ADC_W      = 12;
    localparam int DEF_DUMMY_LEAD = 32;
    localparam int DEF_ACTIVE_PIX = 5340;
    localparam int DEF_SAMPLE_DLY = 8;
    localparam int DEF_AW         = 13;

    localparam int SAMPLE_DLY_MIN = 1;
    localparam int SAMPLE_DLY_MAX = 40;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_CAPTURE = 2'd1,
        WR_DROP    = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    function automatic bit sample_dly_legal(input int dly);
        return (dly >= SAMPLE_DLY_MIN) && (dly <= SAMPLE_DLY_MAX);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccd_line_ram.sv
// ----------------------------------------------------------------------------
// ccd_line_ram : two-bank line buffer, one write port, one registered read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ccd_line_ram #(
    parameter int ADC_W = 12,
    parameter int AW    = 13
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW:0]      waddr,
    input  logic [ADC_W-1:0] wdata,
    input  logic             re,
    input  logic [AW:0]      raddr,
    output logic [ADC_W-1:0] rdata_q
);

    logic [ADC_W-1:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ccd_line_capture.sv
// ----------------------------------------------------------------------------
// ccd_line_capture : samples TCD1500C video into a ping-pong buffer, streams lines out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ccd_line_capture
    import ccd_capture_pkg::*;
#(
    parameter int ADC_W      = DEF_ADC_W,
    parameter int DUMMY_LEAD = DEF_DUMMY_LEAD,
    parameter int ACTIVE_PIX = DEF_ACTIVE_PIX,
    parameter int SAMPLE_DLY = DEF_SAMPLE_DLY,
    parameter int AW         = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sh,
    input  logic             sp,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [7:0]       drop_cnt,
    output logic             busy
);

    localparam int IDX_W = $clog2(DUMMY_LEAD + ACTIVE_PIX + 1);
    localparam int DLY_W = $clog2(SAMPLE_DLY + 1);

    localparam logic [IDX_W-1:0] c_lead      = IDX_W'(DUMMY_LEAD);
    localparam logic [IDX_W-1:0] c_end       = IDX_W'(DUMMY_LEAD + ACTIVE_PIX);
    localparam logic [AW-1:0]    c_last_addr = AW'(ACTIVE_PIX - 1);
    localparam logic [DLY_W-1:0] c_dly       = DLY_W'(SAMPLE_DLY);
    localparam logic [DLY_W-1:0] c_dly_one   = DLY_W'(1);
    localparam bit               c_one_pix   = (ACTIVE_PIX == 1);

    if (!sample_dly_legal(SAMPLE_DLY)) begin : g_bad_sample_dly
        $error("ccd_line_capture: SAMPLE_DLY out of range 1..40");
    end
    if ((2**AW) < ACTIVE_PIX) begin : g_bad_aw
        $error("ccd_line_capture: AW too small for ACTIVE_PIX");
    end

    // ------------------------------------------------------------------ state
    logic             sh_q, sp_q;
    wr_state_e        wr_state_q, wr_state_d;
    logic             wbank_q, wbank_d;
    logic [IDX_W-1:0] sp_idx_q, sp_idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             dly_act_q, dly_act_d;
    logic             samp_v_q, samp_v_d;
    logic [ADC_W-1:0] samp_data_q, samp_data_d;
    logic [IDX_W-1:0] samp_idx_q, samp_idx_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             oldest_q, oldest_d;

    rd_state_e        rd_state_q, rd_state_d;
    logic             rbank_q, rbank_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_last_q, rd_last_d;
    logic [ADC_W-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [ADC_W-1:0] skid_data_q, skid_data_d;
    logic             skid_v_q, skid_v_d;
    logic             skid_last_q, skid_last_d;

    // ------------------------------------------------------------ combinational
    logic             w_sh_rise, w_sp_rise;
    logic [IDX_W-1:0] w_wr_off;
    logic [AW-1:0]    w_wr_addr;
    logic             w_in_range, w_wr_last;
    logic [1:0]       set_full, clr_full, full_now;
    logic             ram_we, ram_re, line_done;
    logic [AW:0]      ram_raddr;
    logic [ADC_W-1:0] ram_rdata;
    logic             w_pop, w_can_issue, w_rd_sel;
    logic [1:0]       w_occ;

    assign w_sh_rise  = sh & ~sh_q;
    assign w_sp_rise  = sp & ~sp_q;
    assign w_wr_off   = samp_idx_q - c_lead;
    assign w_wr_addr  = AW'(w_wr_off);
    assign w_in_range = (samp_idx_q >= c_lead) && (samp_idx_q < c_end);
    assign w_wr_last  = (w_wr_addr == c_last_addr);

    // Writer: sample pipeline, buffer writes and line start / abort handling
    always_comb begin
        wr_state_d  = wr_state_q;
        wbank_d     = wbank_q;
        sp_idx_d    = sp_idx_q;
        dly_d       = dly_q;
        dly_act_d   = dly_act_q;
        samp_v_d    = 1'b0;
        samp_data_d = samp_data_q;
        samp_idx_d  = samp_idx_q;
        drop_cnt_d  = drop_cnt_q;
        set_full    = 2'b00;
        ram_we      = 1'b0;
        line_done   = 1'b0;
        full_now    = full_q;

        if ((wr_state_q == WR_CAPTURE) && samp_v_q && w_in_range) begin
            ram_we = 1'b1;
            if (w_wr_last) begin
                set_full   = 2'b01 << wbank_q;
                line_done  = 1'b1;
                wr_state_d = WR_IDLE;
                dly_act_d  = 1'b0;
            end
        end

        if ((wr_state_q == WR_CAPTURE) && !line_done) begin
            if (w_sp_rise) begin
                dly_d     = c_dly;
                dly_act_d = 1'b1;
            end else if (dly_act_q) begin
                if (dly_q == c_dly_one) begin
                    dly_act_d   = 1'b0;
                    samp_v_d    = 1'b1;
                    samp_data_d = adc_data;
                    samp_idx_d  = sp_idx_q;
                    sp_idx_d    = sp_idx_q + IDX_W'(1);
                end else begin
                    dly_d = dly_q - c_dly_one;
                end
            end
        end

        // A bank completing this cycle must not be chosen for the new line.
        if (w_sh_rise) begin
            if ((wr_state_q == WR_CAPTURE) && !line_done) begin
                drop_cnt_d = sat_inc8(drop_cnt_d);
            end
            full_now = full_q | set_full;
            if (!full_now[0] || !full_now[1]) begin
                wr_state_d = WR_CAPTURE;
                wbank_d    = full_now[0];
                sp_idx_d   = '0;
                dly_d      = '0;
                dly_act_d  = 1'b0;
                samp_v_d   = 1'b0;
            end else begin
                wr_state_d = WR_DROP;
                drop_cnt_d = sat_inc8(drop_cnt_d);
            end
        end
    end

    // Bank occupancy and fill order
    always_comb begin
        full_d   = (full_q | set_full) & ~clr_full;
        oldest_d = oldest_q;
        if (|set_full) begin
            if (!(full_q[~wbank_q] && !clr_full[~wbank_q])) begin
                oldest_d = wbank_q;
            end
        end
    end

    assign w_pop       = m_valid_q & m_ready;
    assign w_occ       = {1'b0, m_valid_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q};
    assign w_can_issue = (w_occ - {1'b0, w_pop}) < 2'd2;
    assign w_rd_sel    = (full_q == 2'b11) ? oldest_q : full_q[1];

    // Reader: reads are only issued while the output + skid stages have room
    always_comb begin
        rd_state_d = rd_state_q;
        rbank_d    = rbank_q;
        rd_addr_d  = rd_addr_q;
        rd_pend_d  = 1'b0;
        rd_last_d  = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = {rbank_q, rd_addr_q};
        clr_full   = 2'b00;

        case (rd_state_q)
            RD_IDLE: begin
                if ((|full_q) && w_can_issue) begin
                    rbank_d    = w_rd_sel;
                    ram_re     = 1'b1;
                    ram_raddr  = {w_rd_sel, {AW{1'b0}}};
                    rd_pend_d  = 1'b1;
                    rd_last_d  = c_one_pix;
                    rd_addr_d  = AW'(1);
                    rd_state_d = c_one_pix ? RD_STREAM : RD_FETCH;
                end
            end
            RD_FETCH: begin
                if (w_can_issue) begin
                    ram_re    = 1'b1;
                    rd_pend_d = 1'b1;
                    rd_last_d = (rd_addr_q == c_last_addr);
                    rd_addr_d = rd_addr_q + AW'(1);
                    if (rd_addr_q == c_last_addr) begin
                        rd_state_d = RD_STREAM;
                    end
                end
            end
            RD_STREAM: begin
                if (w_pop && m_last_q) begin
                    clr_full   = 2'b01 << rbank_q;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Output register with a one-entry skid for the read in flight
    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;

        if (!m_valid_q || w_pop) begin
            if (skid_v_q) begin
                m_valid_d = 1'b1;
                m_data_d  = skid_data_q;
                m_last_d  = skid_last_q;
                skid_v_d  = 1'b0;
            end else if (rd_pend_q) begin
                m_valid_d = 1'b1;
                m_data_d  = ram_rdata;
                m_last_d  = rd_last_q;
            end else begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        end else if (rd_pend_q) begin
            skid_v_d    = 1'b1;
            skid_data_d = ram_rdata;
            skid_last_d = rd_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q        <= 1'b0;
            sp_q        <= 1'b0;
            wr_state_q  <= WR_IDLE;
            wbank_q     <= 1'b0;
            sp_idx_q    <= '0;
            dly_q       <= '0;
            dly_act_q   <= 1'b0;
            samp_v_q    <= 1'b0;
            samp_data_q <= '0;
            samp_idx_q  <= '0;
            drop_cnt_q  <= 8'd0;
            full_q      <= 2'b00;
            oldest_q    <= 1'b0;
            rd_state_q  <= RD_IDLE;
            rbank_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            skid_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
        end else begin
            sh_q        <= sh;
            sp_q        <= sp;
            wr_state_q  <= wr_state_d;
            wbank_q     <= wbank_d;
            sp_idx_q    <= sp_idx_d;
            dly_q       <= dly_d;
            dly_act_q   <= dly_act_d;
            samp_v_q    <= samp_v_d;
            samp_data_q <= samp_data_d;
            samp_idx_q  <= samp_idx_d;
            drop_cnt_q  <= drop_cnt_d;
            full_q      <= full_d;
            oldest_q    <= oldest_d;
            rd_state_q  <= rd_state_d;
            rbank_q     <= rbank_d;
            rd_addr_q   <= rd_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            skid_data_q <= skid_data_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
        end
    end

    ccd_line_ram #(
        .ADC_W (ADC_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   ({wbank_q, w_wr_addr}),
        .wdata   (samp_data_q),
        .re      (ram_re),
        .raddr   (ram_raddr),
        .rdata_q (ram_rdata)
    );

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (wr_state_q != WR_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ccd_line_capture.sv
// ----------------------------------------------------------------------------
// tb_ccd_line_capture : scoreboard bench for ccd_line_capture (scaled-down line)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ccd_line_capture;

    localparam int ADC_W      = 12;
    localparam int DUMMY      = 32;
    localparam int ACTIVE     = 40;
    localparam int SAMPLE_DLY = 8;
    localparam int AW         = 6;
    localparam int SP_PER     = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sh, sp;
    logic [ADC_W-1:0] adc_data;
    logic [ADC_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [7:0]       drop_cnt;
    logic             busy;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               words_seen = 0;
    int               rdy_mode = 0;
    logic [ADC_W:0]   exp_q[$];
    logic [ADC_W:0]   exp_w;
    logic             hold_prev = 1'b0;
    logic [ADC_W-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    always #5 clk = ~clk;

    ccd_line_capture #(
        .ADC_W      (ADC_W),
        .DUMMY_LEAD (DUMMY),
        .ACTIVE_PIX (ACTIVE),
        .SAMPLE_DLY (SAMPLE_DLY),
        .AW         (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sh       (sh),
        .sp       (sp),
        .adc_data (adc_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic sh_pulse();
        sh = 1'b1;
        tick(3);
        sh = 1'b0;
        tick(3);
    endtask

    task automatic sp_pulses(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            adc_data = ADC_W'(base + k);
            sp = 1'b1;
            tick(2);
            sp = 1'b0;
            tick(SP_PER - 2);
        end
    endtask

    task automatic push_line(input int base);
        logic           lst;
        logic [ADC_W-1:0] val;
        for (int k = DUMMY; k < DUMMY + ACTIVE; k++) begin
            lst = (k == DUMMY + ACTIVE - 1);
            val = ADC_W'(base + k);
            exp_q.push_back({lst, val});
        end
    endtask

    task automatic full_line(input int base, input bit captured);
        if (captured) push_line(base);
        sh_pulse();
        sp_pulses(DUMMY + ACTIVE, base);
        tick(6);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || m_valid) && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // m_ready driver
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    n_tests++;
                    if (!m_valid || m_data != prev_data || m_last != prev_last) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%0d d=%0d l=%0d, required v=1 d=%0d l=%0d",
                                 m_valid, m_data, m_last, prev_data, prev_last);
                    end
                end
                if (m_valid && m_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got d=%0d l=%0d, required no word", m_data, m_last);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if ({m_last, m_data} !== exp_w) begin
                            n_fail++;
                            $display("FAIL word: got d=%0d l=%0d, required d=%0d l=%0d",
                                     m_data, m_last, exp_w[ADC_W-1:0], exp_w[ADC_W]);
                        end
                    end
                    words_seen++;
                end
                hold_prev = m_valid && !m_ready;
                prev_data = m_data;
                prev_last = m_last;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int cyc;
        rst_n    = 1'b0;
        sh       = 1'b0;
        sp       = 1'b0;
        adc_data = '0;
        rdy_mode = 0;
        tick(4);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(3);

        // Nominal line
        push_line(0);
        sh_pulse();
        check("busy_capture", int'(busy), 1);
        sp_pulses(DUMMY + ACTIVE, 0);
        tick(6);
        drain("nominal_drain");
        check("nominal_drop", int'(drop_cnt), 0);
        check("nominal_idle", int'(busy), 0);

        // Backpressure
        rdy_mode = 1;
        full_line(300, 1'b1);
        full_line(600, 1'b1);
        drain("bp_drain");
        check("bp_drop", int'(drop_cnt), 0);

        // Overrun: two lines buffered, third dropped, oldest first
        rdy_mode = 2;
        tick(2);
        full_line(1000, 1'b1);
        full_line(2000, 1'b1);
        full_line(3000, 1'b0);
        check("overrun_drop", int'(drop_cnt), 1);
        rdy_mode = 0;
        drain("overrun_drain");

        // Short line aborted by the next sh rise
        sh_pulse();
        sp_pulses(50, 3500);
        tick(4);
        full_line(4000, 1'b1);
        drain("short_drain");
        check("short_drop", int'(drop_cnt), 2);

        // Reset in the middle of a stream
        push_line(0);
        w0 = words_seen;
        sh_pulse();
        sp_pulses(DUMMY + ACTIVE, 0);
        cyc = 0;
        while (words_seen < w0 + 20 && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        check("reset_reach_word20", int'(words_seen >= w0 + 20), 1);
        rst_n = 1'b0;
        exp_q.delete();
        tick(1);
        check("midrst_m_data", int'(m_data), 0);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_last", int'(m_last), 0);
        check("midrst_drop_cnt", int'(drop_cnt), 0);
        check("midrst_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        full_line(0, 1'b1);
        drain("post_reset_drain");

        // Saturation: both banks held full, then 300 drops
        rdy_mode = 2;
        tick(2);
        full_line(100, 1'b1);
        full_line(200, 1'b1);
        check("sat_fill_drop", int'(drop_cnt), 0);
        repeat (10) sh_pulse();
        check("sat_drop10", int'(drop_cnt), 10);
        repeat (290) sh_pulse();
        check("sat_drop300", int'(drop_cnt), 255);
        rdy_mode = 0;
        drain("sat_drain");
        check("sat_hold", int'(drop_cnt), 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
